// File: rtl/ght_pkg.sv
// ght_pkg: shared GHT index width and queued-update entry layout.
package ght_pkg;
  localparam int GHT_AW = 13;
  typedef struct packed {
    logic              valid;
    logic              thread;
    logic [GHT_AW-1:0] addr;
    logic [1:0]        data;
  } ght_upd_t;
endpackage

// File: rtl/ght_upd_slot.sv
// ght_upd_slot: one queue entry; a write loads it, a matching-thread flush kills it.
module ght_upd_slot
  import ght_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we,
  input  ght_upd_t din,
  input  logic     flush,
  input  logic     flush_thread,
  output ght_upd_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (we) q <= din;
    else if (flush && q.thread == flush_thread) q.valid <= 1'b0;
endmodule

// File: rtl/ght_upd_queue.sv
// ght_upd_queue: buffers up to two GHT counter updates per cycle, drains one write per cycle.
module ght_upd_queue
  import ght_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = GHT_AW,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upd0_en,
  input  logic [AW-1:0] upd0_addr,
  input  logic [DW-1:0] upd0_data,
  input  logic          upd0_thread,
  input  logic          upd1_en,
  input  logic [AW-1:0] upd1_addr,
  input  logic [DW-1:0] upd1_data,
  input  logic          upd1_thread,
  output logic          upd_stall,
  input  logic          wr_ready,
  output logic          write_wen,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data,
  output logic          write_thread,
  input  logic          except,
  input  logic          except_thread
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head, tail, tail1;
  logic [PW:0]   count, count_next;
  logic [1:0]    n_enq;
  logic          k0, k1, coal, w0, live, pop;
  ght_upd_t      e0, e1, hd;
  ght_upd_t      slots [DEPTH];
  // Updates of a thread being flushed this edge never get a slot.
  assign k0 = upd0_en & ~upd_stall & ~(except & (upd0_thread == except_thread));
  assign k1 = upd1_en & ~upd_stall & ~(except & (upd1_thread == except_thread));
  assign coal = k0 & k1 & (upd0_addr == upd1_addr) & (upd0_thread == upd1_thread);
  assign w0 = k0 & ~coal;
  assign n_enq = {1'b0, w0} + {1'b0, k1};
  assign tail1 = tail + 1'b1;
  assign e0 = {1'b1, upd0_thread, upd0_addr, upd0_data};
  assign e1 = {1'b1, upd1_thread, upd1_addr, upd1_data};
  assign hd = slots[head];
  // A head entry flushed on this very edge retires silently instead of writing.
  assign live = (count != '0) & hd.valid & ~(except & (hd.thread == except_thread));
  assign pop = (count != '0) & (wr_ready | ~live);
  assign count_next = count + (PW+1)'(n_enq) - (PW+1)'(pop);
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic     we;
    ght_upd_t din;
    assign we = ((PW'(i) == tail) & (w0 | k1)) | ((PW'(i) == tail1) & w0 & k1);
    assign din = (PW'(i) == tail) ? (w0 ? e0 : e1) : e1;
    ght_upd_slot u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (we),
      .din         (din),
      .flush       (except),
      .flush_thread(except_thread),
      .q           (slots[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      upd_stall <= 1'b0;
      write_wen <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      write_thread <= 1'b0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(n_enq);
      count <= count_next;
      upd_stall <= count_next > (PW+1)'(DEPTH - 2);
      write_wen <= pop & live;
      if (pop & live) begin
        write_addr <= hd.addr;
        write_data <= hd.data;
        write_thread <= hd.thread;
      end
    end
endmodule

// File: tb/tb_ght_upd_queue.sv
// tb_ght_upd_queue: directed and random stimulus checked against a queue-based reference model.
module tb_ght_upd_queue;
  localparam int DEPTH = 8;
  logic clk = 0, rst_n = 0;
  logic upd0_en = 0, upd0_thread = 0, upd1_en = 0, upd1_thread = 0;
  logic [12:0] upd0_addr = 0, upd1_addr = 0;
  logic [1:0] upd0_data = 0, upd1_data = 0;
  logic wr_ready = 0, except = 0, except_thread = 0;
  logic upd_stall, write_wen, write_thread;
  logic [12:0] write_addr;
  logic [1:0] write_data;

  ght_upd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd0_en(upd0_en), .upd0_addr(upd0_addr), .upd0_data(upd0_data), .upd0_thread(upd0_thread),
    .upd1_en(upd1_en), .upd1_addr(upd1_addr), .upd1_data(upd1_data), .upd1_thread(upd1_thread),
    .upd_stall(upd_stall), .wr_ready(wr_ready),
    .write_wen(write_wen), .write_addr(write_addr), .write_data(write_data), .write_thread(write_thread),
    .except(except), .except_thread(except_thread)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; bit t; int a; int d;} ent_t;
  ent_t mq[$];
  int dlog[$];
  bit ewen, estall, ethr;
  int eaddr, edata;
  int cmp = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(int s, int a, int d, bit t);
    if (s == 0) begin upd0_en = 1; upd0_addr = 13'(a); upd0_data = 2'(d); upd0_thread = t; end
    else begin upd1_en = 1; upd1_addr = 13'(a); upd1_data = 2'(d); upd1_thread = t; end
  endtask

  // Model one clock edge from the spec's queue rules, then compare the DUT after it.
  task automatic step(string tag);
    bit live, pop, e0, e1;
    live = mq.size() > 0 && mq[0].v && !(except && mq[0].t == except_thread);
    pop = mq.size() > 0 && (wr_ready || !live);
    e0 = upd0_en && !estall && !(except && upd0_thread == except_thread);
    e1 = upd1_en && !estall && !(except && upd1_thread == except_thread);
    ewen = pop && live;
    if (ewen) begin eaddr = mq[0].a; edata = mq[0].d; ethr = mq[0].t; end
    if (except) foreach (mq[i]) if (mq[i].t == except_thread) mq[i].v = 0;
    if (pop) void'(mq.pop_front());
    if (e0 && e1 && upd0_addr == upd1_addr && upd0_thread == upd1_thread)
      mq.push_back('{1, upd1_thread, int'(upd1_addr), int'(upd1_data)});
    else begin
      if (e0) mq.push_back('{1, upd0_thread, int'(upd0_addr), int'(upd0_data)});
      if (e1) mq.push_back('{1, upd1_thread, int'(upd1_addr), int'(upd1_data)});
    end
    estall = (DEPTH - mq.size()) < 2;
    @(posedge clk);
    #1;
    upd0_en = 0; upd1_en = 0; except = 0;
    if (write_wen === 1'b1) dlog.push_back(int'(write_addr));
    chk({tag, ".wen"}, 32'(write_wen), 32'(ewen));
    chk({tag, ".stall"}, 32'(upd_stall), 32'(estall));
    chk({tag, ".addr"}, 32'(write_addr), 32'(eaddr));
    chk({tag, ".data"}, 32'(write_data), 32'(edata));
    chk({tag, ".thr"}, 32'(write_thread), 32'(ethr));
  endtask

  task automatic steps(string tag, int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset(string tag);
    #2 rst_n = 0;
    #1;
    chk({tag, ".rst_wen"}, 32'(write_wen), 0);
    chk({tag, ".rst_stall"}, 32'(upd_stall), 0);
    chk({tag, ".rst_addr"}, 32'(write_addr), 0);
    mq.delete();
    ewen = 0; estall = 0; ethr = 0; eaddr = 0; edata = 0;
    #2 rst_n = 1;
  endtask

  initial begin
    ewen = 0; estall = 0; ethr = 0; eaddr = 0; edata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init.wen", 32'(write_wen), 0);
    chk("init.stall", 32'(upd_stall), 0);
    chk("init.data", 32'(write_data), 0);
    rst_n = 1;
    // single update: write two edges after enqueue, exactly once
    wr_ready = 1; dlog.delete();
    put(0, 'h0A5, 2, 0); step("single");
    chk("single.early", 32'(write_wen), 0);
    steps("single", 4);
    chk("single.cnt", dlog.size(), 1);
    chk("single.a", dlog[0], 'h0A5);
    // coalesce same addr/thread, then two distinct addrs
    dlog.delete();
    put(0, 'h123, 1, 1); put(1, 'h123, 3, 1); steps("coal", 4);
    chk("coal.cnt", dlog.size(), 1);
    chk("coal.a", dlog[0], 'h123);
    dlog.delete();
    put(0, 'h010, 1, 0); put(1, 'h020, 2, 0); steps("dist", 4);
    chk("dist.cnt", dlog.size(), 2);
    chk("dist.a0", dlog[0], 'h010);
    chk("dist.a1", dlog[1], 'h020);
    // backpressure: 6 queued leaves exactly 2 free, the 7th raises stall
    wr_ready = 0; dlog.delete();
    for (int i = 0; i < 3; i++) begin put(0, 'h100 + 2*i, i, 0); put(1, 'h101 + 2*i, 3, 1); step("bp"); end
    chk("bp.six", 32'(upd_stall), 0);
    put(0, 'h1FF, 1, 0); step("bp");
    chk("bp.seven", 32'(upd_stall), 1);
    wr_ready = 1; step("bp");
    chk("bp.drop", 32'(upd_stall), 0);
    steps("bp", 9);
    chk("bp.cnt", dlog.size(), 7);
    for (int i = 0; i < 6; i++) chk("bp.order", dlog[i], 'h100 + i);
    // flush thread 0: only B and D survive
    wr_ready = 0; dlog.delete();
    put(0, 'hA, 0, 0); put(1, 'hB, 1, 1); step("fl");
    put(0, 'hC, 2, 0); put(1, 'hD, 3, 1); step("fl");
    except = 1; except_thread = 0; step("fl");
    wr_ready = 1; steps("fl", 6);
    chk("fl.cnt", dlog.size(), 2);
    chk("fl.b", dlog[0], 'hB);
    chk("fl.d", dlog[1], 'hD);
    // wrap: 20 single updates back to back
    dlog.delete();
    for (int i = 0; i < 20; i++) begin put(0, 'h200 + i, i % 4, i % 2); step("wrap"); end
    steps("wrap", 4);
    chk("wrap.cnt", dlog.size(), 20);
    for (int i = 0; i < 20; i++) chk("wrap.order", dlog[i], 'h200 + i);
    chk("wrap.empty_stall", 32'(upd_stall), 0);
    // reset mid-stream with 5 queued
    wr_ready = 0;
    put(0, 'h300, 1, 0); put(1, 'h301, 1, 0); step("mrst");
    put(0, 'h302, 1, 1); put(1, 'h303, 1, 1); step("mrst");
    put(0, 'h304, 1, 0); step("mrst");
    do_reset("mrst");
    wr_ready = 1; dlog.delete();
    steps("mrst", 5);
    chk("mrst.nowr", dlog.size(), 0);
    // random traffic with flushes
    for (int i = 0; i < 400; i++) begin
      wr_ready = ($urandom % 4) != 0;
      if (!estall && ($urandom % 3) != 0) put(0, $urandom % 8, $urandom % 4, $urandom % 2);
      if (!estall && ($urandom % 3) != 0) put(1, $urandom % 8, $urandom % 4, $urandom % 2);
      if (($urandom % 10) == 0) begin except = 1; except_thread = $urandom % 2; end
      step("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
